// File: rtl/array_pkg.sv
// Shared serializer constants and FSM state encoding.
package array_pkg;
   localparam int ROW_DEF   = 8;
   localparam int COL_DEF   = 4;
   localparam int WIDTH_DEF = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      CSUM = 2'd2
   } state_t;
endpackage

// File: rtl/array_index_ctr.sv
// Row/column walker with wrap, row- or column-major; latency 0 (registered indices, combinational last).
// Backpressure: moves only when advance is high; clear restarts at (0,0).
module array_index_ctr
   import array_pkg::*;
#(
   parameter int ROW = ROW_DEF,
   parameter int COL = COL_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   advance,
   input  logic                   transpose,
   output logic [$clog2(ROW)-1:0] row,
   output logic [$clog2(COL)-1:0] col,
   output logic                   last
);
   localparam int RW = $clog2(ROW);
   localparam int CW = $clog2(COL);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROW - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(COL - 1);

   logic row_end;
   logic col_end;

   assign row_end = (row == ROW_MAX);
   assign col_end = (col == COL_MAX);
   // Both orders finish on the bottom-right element.
   assign last    = row_end && col_end;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (!transpose) begin
            if (col_end) begin
               col <= '0;
               row <= row_end ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end else begin
            if (row_end) begin
               row <= '0;
               col <= col_end ? '0 : col + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/array_serializer.sv
// Captures a ROW x COL array and emits one element per beat; first beat 1 cycle after accept, holds on out_ready=0.
// ARRAY_SERIALIZER_CHECKSUM_EN appends a mod-2^WIDTH sum beat after the last element.
module array_serializer
   import array_pkg::*;
#(
   parameter int ROW   = ROW_DEF,
   parameter int COL   = COL_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [ROW-1:0][COL-1:0][WIDTH-1:0]   array_in,
   input  logic                                 in_transpose,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [WIDTH-1:0]                     out_data,
   output logic [$clog2(ROW)-1:0]               out_row,
   output logic [$clog2(COL)-1:0]               out_col,
   output logic                                 out_last
);
   localparam int RW = $clog2(ROW);
   localparam int CW = $clog2(COL);

   state_t                            state;
   state_t                            state_nxt;
   logic [ROW-1:0][COL-1:0][WIDTH-1:0] arr_q;
   logic                              transpose_q;
   logic                              accept;
   logic                              elem_beat;
   logic                              idx_last;
   logic [RW-1:0]                     idx_row;
   logic [CW-1:0]                     idx_col;
   logic [WIDTH-1:0]                  elem;

   assign accept    = in_valid && in_ready;
   assign elem_beat = (state == SEND) && out_valid && out_ready;
   assign elem      = arr_q[idx_row][idx_col];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         arr_q       <= '0;
         transpose_q <= 1'b0;
      end else if (accept) begin
         arr_q       <= array_in;
         transpose_q <= in_transpose;
      end
   end

   array_index_ctr #(
      .ROW (ROW),
      .COL (COL)
   ) u_idx (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (accept),
      .advance   (elem_beat),
      .transpose (transpose_q),
      .row       (idx_row),
      .col       (idx_col),
      .last      (idx_last)
   );

`ifdef ARRAY_SERIALIZER_CHECKSUM_EN
   logic [WIDTH-1:0] csum_q;

   always_ff @(posedge clk) begin
      if (!rst_n || accept) begin
         csum_q <= '0;
      end else if (elem_beat) begin
         csum_q <= csum_q + elem;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = elem;
      out_row   = idx_row;
      out_col   = idx_col;
      out_last  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SEND;
         end
         SEND: begin
            out_valid = 1'b1;
`ifdef ARRAY_SERIALIZER_CHECKSUM_EN
            if (out_ready && idx_last) state_nxt = CSUM;
`else
            out_last = idx_last;
            if (out_ready && idx_last) state_nxt = IDLE;
`endif
         end
`ifdef ARRAY_SERIALIZER_CHECKSUM_EN
         CSUM: begin
            out_valid = 1'b1;
            out_data  = csum_q;
            out_row   = '0;
            out_col   = '0;
            out_last  = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
      // Outputs are forced quiet for the whole time reset is held.
      if (!rst_n) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
         out_data  = '0;
         out_row   = '0;
         out_col   = '0;
         out_last  = 1'b0;
      end
   end
endmodule

// File: tb/tb_array_serializer.sv
// Randomized bench for array_serializer against a queue-based beat model.
module tb_array_serializer;
   localparam int ROW   = 8;
   localparam int COL   = 4;
   localparam int WIDTH = 10;
   localparam int N     = ROW * COL;

   typedef logic [ROW-1:0][COL-1:0][WIDTH-1:0] arr_t;

   logic                     clk;
   logic                     rst_n;
   logic                     in_valid;
   logic                     in_ready;
   arr_t                     array_in;
   logic                     in_transpose;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_data;
   logic [$clog2(ROW)-1:0]   out_row;
   logic [$clog2(COL)-1:0]   out_col;
   logic                     out_last;

   array_serializer #(
      .ROW   (ROW),
      .COL   (COL),
      .WIDTH (WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .array_in     (array_in),
      .in_transpose (in_transpose),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_row      (out_row),
      .out_col      (out_col),
      .out_last     (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int exp_d[$];
   int exp_r[$];
   int exp_c[$];
   int exp_l[$];

   logic hold_next;
   arr_t next_arr;
   logic next_tr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic arr_t rand_arr();
      arr_t a;
      for (int r = 0; r < ROW; r++)
         for (int c = 0; c < COL; c++)
            a[r][c] = WIDTH'($urandom);
      return a;
   endfunction

   function automatic logic pick_ready(input int mode, input int cyc);
      case (mode)
         0: return 1'b1;
         1: return (cyc % 4 == 0) || (cyc % 4 == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Expected beat list: element k of the walk, then optionally the sum beat.
   task automatic build_model(input arr_t a, input logic tr);
      int sum;
      int r;
      int c;
      int last_el;
      sum = 0;
`ifdef ARRAY_SERIALIZER_CHECKSUM_EN
      last_el = 0;
`else
      last_el = 1;
`endif
      exp_d.delete(); exp_r.delete(); exp_c.delete(); exp_l.delete();
      for (int k = 0; k < N; k++) begin
         r = tr ? k % ROW : k / COL;
         c = tr ? k / ROW : k % COL;
         exp_d.push_back(int'(a[r][c]));
         exp_r.push_back(r);
         exp_c.push_back(c);
         exp_l.push_back((k == N - 1) ? last_el : 0);
         sum += int'(a[r][c]);
      end
`ifdef ARRAY_SERIALIZER_CHECKSUM_EN
      exp_d.push_back(sum % (1 << WIDTH));
      exp_r.push_back(0);
      exp_c.push_back(0);
      exp_l.push_back(1);
`endif
   endtask

   // stop_after >= 0 abandons the array after that many accepted beats.
   task automatic send_array(input arr_t a, input logic tr, input int mode, input int stop_after);
      int t;
      int cyc;
      int got;
      int n0;
      t = 0; cyc = 0; got = 0;
      while (!in_ready && t < 200) begin
         step();
         t++;
      end
      check("in_ready_before_accept", in_ready, 1);
      build_model(a, tr);
      n0 = exp_d.size();
      in_valid     = 1'b1;
      array_in     = a;
      in_transpose = tr;
      out_ready    = 1'b0;
      step();
      if (hold_next) begin
         array_in     = next_arr;
         in_transpose = next_tr;
      end else begin
         in_valid     = 1'b0;
         array_in     = rand_arr();
         in_transpose = 1'($urandom);
      end
      check("first_beat_latency", out_valid, 1);
      while (exp_d.size() > 0 && cyc < 2000) begin
         if (stop_after >= 0 && got == stop_after) break;
         out_ready = pick_ready(mode, cyc);
         check("out_valid", out_valid, 1);
         check("in_ready_busy", in_ready, 0);
         check("out_data", out_data, exp_d[0]);
         check("out_row", out_row, exp_r[0]);
         check("out_col", out_col, exp_c[0]);
         check("out_last", out_last, exp_l[0]);
         step();
         cyc++;
         if (out_ready) begin
            void'(exp_d.pop_front());
            void'(exp_r.pop_front());
            void'(exp_c.pop_front());
            void'(exp_l.pop_front());
            got++;
         end
      end
      if (stop_after < 0) begin
         check("beats_remaining", exp_d.size(), 0);
         check("idle_after_last", in_ready, 1);
         check("valid_after_last", out_valid, 0);
         if (mode == 0) check("sustained_rate", cyc, n0);
      end
   endtask

   arr_t ramp;
   arr_t ones;

   initial begin
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      array_in     = '0;
      in_transpose = 1'b0;
      out_ready    = 1'b0;
      hold_next    = 1'b0;
      next_arr     = '0;
      next_tr      = 1'b0;
      for (int r = 0; r < ROW; r++)
         for (int c = 0; c < COL; c++) begin
            ramp[r][c] = WIDTH'(r * COL + c);
            ones[r][c] = '1;
         end

      repeat (3) step();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_row", out_row, 0);
      check("rst_out_col", out_col, 0);
      rst_n = 1'b1;
      step();
      check("in_ready_after_release", in_ready, 1);

      send_array(ramp, 1'b0, 0, -1);
      send_array(ramp, 1'b1, 0, -1);
      send_array(rand_arr(), 1'b0, 1, -1);
      send_array(rand_arr(), 1'b1, 1, -1);

      next_arr  = rand_arr();
      next_tr   = 1'b1;
      hold_next = 1'b1;
      send_array(ramp, 1'b0, 2, -1);
      hold_next = 1'b0;
      send_array(next_arr, next_tr, 0, -1);

      send_array(ramp, 1'b0, 0, 10);
      rst_n     = 1'b0;
      out_ready = 1'b0;
      step();
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out_row", out_row, 0);
      check("midrst_out_col", out_col, 0);
      rst_n = 1'b1;
      step();
      check("midrst_in_ready_release", in_ready, 1);
      send_array(ramp, 1'b0, 0, -1);

      send_array(ones, 1'b0, 0, -1);

      for (int i = 0; i < 6; i++)
         send_array(rand_arr(), 1'($urandom), 2, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/array_serializer.md
ARRAY_SERIALIZER -- requirements
Module: array_serializer

Interface
REQ-001 SHALL have parameter ROW, default 8, meaning the number of rows in the array.
REQ-002 SHALL have parameter COL, default 4, meaning the number of columns in the array.
REQ-003 SHALL have parameter WIDTH, default 10, meaning the bits per element.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning array_in and in_transpose are offered.
REQ-007 SHALL have port in_ready, output, 1, meaning the block can accept an array.
REQ-008 SHALL have port array_in, input, [ROW-1:0][COL-1:0][WIDTH-1:0], the packed array to serialize.
REQ-009 SHALL have port in_transpose, input, 1, meaning column-major order for this array.
REQ-010 SHALL have port out_valid, output, 1, meaning the output beat is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the sink accepts the beat.
REQ-012 SHALL have port out_data, output, WIDTH, the element value.
REQ-013 SHALL have port out_row, output, clog2(ROW), the row index of the beat.
REQ-014 SHALL have port out_col, output, clog2(COL), the column index of the beat.
REQ-015 SHALL have port out_last, output, 1, marking the final beat of an array.

Function
REQ-016 SHALL capture the whole array_in and in_transpose into an internal buffer on the cycle in_valid && in_ready.
REQ-017 SHALL drive in_ready = 1 only in IDLE, so at most one array is in flight (no double buffering).
REQ-018 SHALL implement the FSM IDLE -> SEND on accept; SEND -> IDLE on the accepted last element (or SEND -> CSUM under REQ-029); CSUM -> IDLE on the accepted checksum beat.
REQ-019 SHALL assert out_valid from the cycle after accept; first-beat latency is 1 cycle.
REQ-020 SHALL order beats row-major when in_transpose=0: (0,0),(0,1)..(0,COL-1),(1,0)..(ROW-1,COL-1).
REQ-021 SHALL order beats column-major when in_transpose=1: (0,0),(1,0)..(ROW-1,0),(0,1)..(ROW-1,COL-1).
REQ-022 SHALL advance indices only on out_valid && out_ready, emitting exactly ROW*COL element beats per array.
REQ-023 SHALL hold out_data, out_row, out_col and out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain one beat per cycle while out_ready=1.
REQ-025 SHALL assert out_last only on the final beat of the array.
REQ-026 SHALL ignore array_in changes after capture; a new in_valid is accepted in IDLE only, which is reached the cycle after the final handshake.

Reset
REQ-027 SHALL, with rst_n=0 at a clock edge, enter IDLE and clear in-flight state, abandoning any partially sent array mid-operation.
REQ-028 SHALL drive these values during reset: in_ready=0, out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0; in_ready=1 the first cycle after reset release.

Configuration
REQ-029 SHALL, with ARRAY_SERIALIZER_CHECKSUM_EN defined, append one CSUM beat after the last element: out_data = sum of all elements mod 2^WIDTH, out_row=0, out_col=0, out_last=1 on the CSUM beat only; the last element beat then has out_last=0.
REQ-030 SHALL, without ARRAY_SERIALIZER_CHECKSUM_EN, have no CSUM state, no accumulator and exactly ROW*COL beats per array.

Structure
REQ-031 SHALL take from the shared package array_pkg: the FSM state enum (IDLE, SEND, CSUM) and the default ROW/COL/WIDTH constants.
REQ-032 SHALL use one sub-module, array_index_ctr: a row/column counter with wrap, an order-select input and a last-flag output.

Verification
REQ-033 SHALL cover: load array with element(i,j)=i*COL+j, in_transpose=0, out_ready=1 -> out_data 0,1,2..31 over 32 consecutive cycles, out_last on beat 31.
REQ-034 SHALL cover: same array, in_transpose=1 -> out_data 0,4,8..28,1,5..31; last beat (7,3)=31.
REQ-035 SHALL cover: out_ready toggling 1,0,0,1 -> no beat lost or duplicated; outputs stable during stalls.
REQ-036 SHALL cover: in_valid held high during SEND -> in_ready=0 and second array accepted only after out_last handshake.
REQ-037 SHALL cover: rst_n=0 after beat 10 -> out_valid=0 next cycle, in_ready=1 after release, next array starts at (0,0).
REQ-038 SHALL cover, with CHECKSUM_EN and all elements = 1023 (WIDTH=10): CSUM beat out_data = (32*1023) mod 1024 = 992, out_last=1.
